mem_arbiter: RTL and testbench

- Shares the single-port 4x8 data memory between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/loader port.
- Requesters use a valid/ready request channel and a one-cycle response pulse.
- The arbiter owns every memory control input (we, addr, data_in).
- It samples the memory's combinational read output one cycle after grant.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/mem_arbiter.sv | 93 +++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 2;
    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter with last_grant history; MEM_ARB_FIXED_PRIO_EN selects
// fixed priority (port 0 always wins a conflict) instead of round-robin.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    import mem_arb_pkg::*;

    logic last_grant;

    // Reset to the debug port so the CPU wins the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (advance)
            last_grant <= gnt[PORT_DBG];
    end

    always_comb begin
        gnt = req;
        if (&req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            gnt = 2'b01;
`else
            gnt = last_grant ? 2'b01 : 2'b10;
`endif
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port combinational-read memory between the CPU (port 0)
// and the debug/loader port (port 1). Optional macro: MEM_ARB_FIXED_PRIO_EN.
module mem_arbiter #(
    parameter int DATA_W = mem_arb_pkg::DATA_W,
    parameter int ADDR_W = mem_arb_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout
);
    import mem_arb_pkg::*;

    state_t              state, state_nxt;
    logic [1:0]          gnt;
    logic                hs;
    logic                op_we;
    logic                op_port;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wdata;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (hs),
        .gnt     (gnt)
    );

    assign hs = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mem_we is decoded from state so an async reset drops it at once.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        mem_we    = 1'b0;
        case (state)
            IDLE:    req_ready = gnt;
            ACCESS:  mem_we = op_we;
            RESP:    rsp_valid[op_port] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_we     <= 1'b0;
            op_port   <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            rsp_rdata <= '0;
        end else begin
            if (state == IDLE && hs) begin
                op_we    <= |(req_we & gnt);
                op_port  <= gnt[PORT_DBG];
                op_addr  <= gnt[PORT_DBG] ? req_addr[PORT_DBG*ADDR_W +: ADDR_W]
                                          : req_addr[PORT_CPU*ADDR_W +: ADDR_W];
                op_wdata <= gnt[PORT_DBG] ? req_wdata[PORT_DBG*DATA_W +: DATA_W]
                                          : req_wdata[PORT_CPU*DATA_W +: DATA_W];
            end
            if (state == ACCESS)
                rsp_rdata <= op_we ? '0 : mem_dout;
        end
    end

    // Address/data are the latched op, so they hold between accesses.
    assign mem_addr = op_addr;
    assign mem_din  = op_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 4x8 memory attached.
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req_we;
    logic [3:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_rdata;
    logic       mem_we;
    logic [1:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    logic [7:0] mem [4];
    logic       mem_init;

    int total = 0;
    int bad   = 0;

    logic [1:0] rsp_port [8];
    logic [7:0] rsp_data [8];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    assign mem_dout = mem[mem_addr];

    always_ff @(posedge clk) begin
        if (mem_init) begin
            mem[0] <= 8'h11;
            mem[1] <= 8'h22;
            mem[2] <= 8'h33;
            mem[3] <= 8'h44;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Runs until nrsp responses are seen; keep=0 drops each port's valid
    // after its handshake, keep=1 holds valid for back-to-back requests.
    task automatic run_ops(input int nrsp, input bit keep);
        int got = 0;
        int cyc = 0;
        logic [1:0] prev = 2'b00;
        logic [1:0] hs;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            chk("one_ready", int'($countones(req_ready) <= 1), 1);
            if (rsp_valid != 2'b00) begin
                chk("rsp_onehot", $countones(rsp_valid), 1);
                chk("rsp_one_cycle", int'(prev), 0);
                rsp_port[got] = rsp_valid;
                rsp_data[got] = rsp_rdata;
                got++;
            end
            prev = rsp_valid;
            if (got == nrsp) break;
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (!keep) req_valid = req_valid & ~hs;
        end
        req_valid = 2'b00;
        if (got != nrsp) chk("timeout_rsp_count", got, nrsp);
    endtask

    initial begin
        rst       = 1'b1;
        mem_init  = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        #1;
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rdata", int'(rsp_rdata), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_din", int'(mem_din), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_init = 1'b0;

        // Port 0 writes 0xA5 to addr 2
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_addr[1:0] = 2'd2; req_wdata[7:0] = 8'hA5;
        #1 chk("wr_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("wr_mem_we", int'(mem_we), 1);
        chk("wr_mem_addr", int'(mem_addr), 2);
        chk("wr_mem_din", int'(mem_din), 8'hA5);
        chk("wr_no_rsp_yet", int'(rsp_valid), 0);
        @(negedge clk);
        chk("wr_rsp_valid", int'(rsp_valid), 1);
        chk("wr_rdata", int'(rsp_rdata), 0);
        chk("wr_resp_we_low", int'(mem_we), 0);
        chk("wr_resp_ready", int'(req_ready), 0);
        @(negedge clk);
        chk("wr_rsp_drop", int'(rsp_valid), 0);
        chk("wr_addr_hold", int'(mem_addr), 2);
        chk("wr_mem2", int'(mem[2]), 8'hA5);

        // Port 1 reads addr 2
        req_valid = 2'b10; req_we = 2'b00; req_addr[3:2] = 2'd2;
        #1 chk("rd_ready", int'(req_ready), 2);
        @(negedge clk);
        req_valid = 2'b00;
        chk("rd_mem_we", int'(mem_we), 0);
        chk("rd_mem_addr", int'(mem_addr), 2);
        @(negedge clk);
        chk("rd_rsp_valid", int'(rsp_valid), 2);
        chk("rd_rdata", int'(rsp_rdata), 8'hA5);
        chk("rd_resp_we", int'(mem_we), 0);

        // Both ports hold reads: alternating grants
        req_we = 2'b00; req_addr = {2'd3, 2'd0};
        req_valid = 2'b11;
        run_ops(4, 1'b1);
        chk("rr_p0", int'(rsp_port[0]), 1);
        chk("rr_p1", int'(rsp_port[1]), 2);
        chk("rr_p2", int'(rsp_port[2]), 1);
        chk("rr_p3", int'(rsp_port[3]), 2);
        chk("rr_d0", int'(rsp_data[0]), 8'h11);
        chk("rr_d1", int'(rsp_data[1]), 8'h44);
        chk("rr_d2", int'(rsp_data[2]), 8'h11);
        chk("rr_d3", int'(rsp_data[3]), 8'h44);

        // Same-address write (port 0) vs read (port 1)
        @(negedge clk);
        req_we = 2'b01; req_addr = {2'd1, 2'd1}; req_wdata = {8'h00, 8'h3C};
        req_valid = 2'b11;
        run_ops(2, 1'b0);
        chk("same_p0", int'(rsp_port[0]), 1);
        chk("same_d0", int'(rsp_data[0]), 0);
        chk("same_p1", int'(rsp_port[1]), 2);
        chk("same_d1", int'(rsp_data[1]), 8'h3C);
        chk("same_mem1", int'(mem[1]), 8'h3C);

        // Reset during ACCESS of a write of 0xFF to addr 3
        @(negedge clk);
        @(negedge clk);
        req_we = 2'b01; req_addr = {2'd0, 2'd3}; req_wdata = {8'h00, 8'hFF};
        req_valid = 2'b01;
        #1 chk("rst_op_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("rst_op_we_before", int'(mem_we), 1);
        rst = 1'b1;
        #1;
        chk("rst_op_we_drop", int'(mem_we), 0);
        chk("rst_op_rsp", int'(rsp_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_op_mem3", int'(mem[3]), 8'h44);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_op_no_rsp", int'(rsp_valid), 0);
        end
        // IDLE with last_grant back to 1: port 0 wins a conflict
        req_we = 2'b00;
        req_valid = 2'b11;
        #1 chk("rst_op_idle_grant", int'(req_ready), 1);
        req_valid = 2'b00;

`ifdef MEM_ARB_FIXED_PRIO_EN
        @(negedge clk);
        req_addr = {2'd3, 2'd0};
        req_valid = 2'b11;
        run_ops(3, 1'b1);
        chk("fx_p0", int'(rsp_port[0]), 1);
        chk("fx_p1", int'(rsp_port[1]), 1);
        chk("fx_p2", int'(rsp_port[2]), 1);
        @(negedge clk);
        req_valid = 2'b10;
        run_ops(1, 1'b0);
        chk("fx_dbg", int'(rsp_port[0]), 2);
        chk("fx_dbg_d", int'(rsp_data[0]), 8'h44);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
